// File: rtl/pc_pkg.sv
// pc_pkg: shared operation encoding and stack-pointer sizing for the RISC-SPM program counter.
package pc_pkg;

    typedef enum logic [2:0] {PC_HOLD, PC_LOAD, PC_CALL, PC_RET, PC_BR, PC_INC} pc_op_e;

    // sp counts 0..depth inclusive, so it needs one more code than the entry index
    function automatic int sp_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// ret_addr_stack: hardware LIFO of return addresses; ignores push when full and pop when empty,
// flagging either case on err_pulse.
module ret_addr_stack
    import pc_pkg::*;
#(
    parameter int WORD_SIZE   = 8,
    parameter int STACK_DEPTH = 4,
    localparam int SPW = sp_width(STACK_DEPTH),
    localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WORD_SIZE-1:0] push_data,
    output logic [WORD_SIZE-1:0] top_data,
    output logic [SPW-1:0]       sp,
    output logic                 full,
    output logic                 empty,
    output logic                 err_pulse
);

    logic [WORD_SIZE-1:0] mem_q [STACK_DEPTH];
    logic [SPW-1:0]       sp_q, sp_d;
    logic                 do_push, do_pop;

    assign full      = sp_q == SPW'(STACK_DEPTH);
    assign empty     = sp_q == '0;
    assign sp        = sp_q;
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~push & ~empty;
    assign err_pulse = (push & full) | (pop & ~push & empty);
    assign top_data  = mem_q[IW'(sp_q - 1'b1)];

    always_comb begin
        sp_d = do_push ? sp_q + 1'b1 : do_pop ? sp_q - 1'b1 : sp_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sp_q <= '0;
        else      sp_q <= sp_d;
    end

    // Contents are don't-care after reset, so the array carries no reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[IW'(sp_q)] <= push_data;
    end

endmodule

// File: rtl/pc_call_stack.sv
// pc_call_stack: program counter with load, increment, signed relative branch and
// call/return through an internal return-address stack with sticky error flag.
module pc_call_stack
    import pc_pkg::*;
#(
    parameter int WORD_SIZE   = 8,
    parameter int STACK_DEPTH = 4,
    parameter int INC_STEP    = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [WORD_SIZE-1:0]               data_in,
    input  logic [WORD_SIZE-1:0]               offset,
    input  logic                               Load_PC,
    input  logic                               Call_PC,
    input  logic                               Ret_PC,
    input  logic                               Br_PC,
    input  logic                               Inc_PC,
    input  logic                               Clr_Err,
    output logic [WORD_SIZE-1:0]               count,
    output logic [sp_width(STACK_DEPTH)-1:0]   stk_sp,
    output logic                               stk_full,
    output logic                               stk_empty,
    output logic                               stk_err
);

    localparam logic [WORD_SIZE-1:0] STEP = WORD_SIZE'(INC_STEP);

    pc_op_e               op;
    logic [WORD_SIZE-1:0] count_q, count_d, top_data, ret_addr;
    logic                 err_q, err_d, err_pulse;

    always_comb begin
        op = Load_PC ? PC_LOAD :
             Call_PC ? PC_CALL :
             Ret_PC  ? PC_RET  :
             Br_PC   ? PC_BR   :
             Inc_PC  ? PC_INC  : PC_HOLD;
    end

    assign ret_addr = count_q + STEP;

    ret_addr_stack #(
        .WORD_SIZE  (WORD_SIZE),
        .STACK_DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk      (clk),
        .rst      (rst),
        .push     (op == PC_CALL),
        .pop      (op == PC_RET),
        .push_data(ret_addr),
        .top_data (top_data),
        .sp       (stk_sp),
        .full     (stk_full),
        .empty    (stk_empty),
        .err_pulse(err_pulse)
    );

    // Wrap-around add of the two's-complement offset is plain modular addition
    always_comb begin
        count_d = (op == PC_LOAD)             ? data_in :
                  (op == PC_CALL && !stk_full)  ? data_in :
                  (op == PC_RET  && !stk_empty) ? top_data :
                  (op == PC_BR)               ? count_q + offset :
                  (op == PC_INC)              ? count_q + STEP : count_q;
        err_d   = err_pulse | (err_q & ~Clr_Err);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count   = count_q;
    assign stk_err = err_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// tb_pc_call_stack: directed table-driven check of pc_call_stack (WORD_SIZE=8, STACK_DEPTH=4, INC_STEP=1)
// plus hand-written sequences for asynchronous reset behaviour.
module tb_pc_call_stack;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = '0, offset = '0;
    logic       Load_PC = 0, Call_PC = 0, Ret_PC = 0, Br_PC = 0, Inc_PC = 0, Clr_Err = 0;
    logic [7:0] count;
    logic [2:0] stk_sp;
    logic       stk_full, stk_empty, stk_err;

    int n_chk = 0;
    int n_fail = 0;

    pc_call_stack #(.WORD_SIZE(8), .STACK_DEPTH(4), .INC_STEP(1)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .offset(offset),
        .Load_PC(Load_PC), .Call_PC(Call_PC), .Ret_PC(Ret_PC), .Br_PC(Br_PC),
        .Inc_PC(Inc_PC), .Clr_Err(Clr_Err), .count(count), .stk_sp(stk_sp),
        .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [5:0] cmd;   // {ld, call, ret, br, inc, clr}
        logic [7:0] data;
        logic [7:0] off;
        logic [7:0] e_count;
        logic [2:0] e_sp;
        logic [2:0] e_flags; // {full, empty, err}
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string n, input logic [5:0] c, input logic [7:0] d, input logic [7:0] o,
                                input logic [7:0] ec, input logic [2:0] es, input logic [2:0] ef);
        vec_t v;
        v.name = n; v.cmd = c; v.data = d; v.off = o; v.e_count = ec; v.e_sp = es; v.e_flags = ef;
        vecs.push_back(v);
    endfunction

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic check_all(input string n, input logic [7:0] ec, input logic [2:0] es, input logic [2:0] ef);
        check({n, ".count"}, 32'(count), 32'(ec));
        check({n, ".sp"}, 32'(stk_sp), 32'(es));
        check({n, ".flags"}, 32'({stk_full, stk_empty, stk_err}), 32'(ef));
    endtask

    task automatic step(input logic [5:0] c, input logic [7:0] d, input logic [7:0] o);
        @(negedge clk);
        {Load_PC, Call_PC, Ret_PC, Br_PC, Inc_PC, Clr_Err} = c;
        data_in = d;
        offset  = o;
        @(posedge clk);
        #1;
        {Load_PC, Call_PC, Ret_PC, Br_PC, Inc_PC, Clr_Err} = '0;
    endtask

    localparam logic [5:0] LD = 6'b100000, CL = 6'b010000, RT = 6'b001000,
                           BR = 6'b000100, IN = 6'b000010, CE = 6'b000001, NO = 6'b000000;

    initial begin
        add("load10",   LD,      8'h10, 8'h00, 8'h10, 3'd0, 3'b010);
        add("inc1",     IN,      8'h00, 8'h00, 8'h11, 3'd0, 3'b010);
        add("inc2",     IN,      8'h00, 8'h00, 8'h12, 3'd0, 3'b010);
        add("inc3",     IN,      8'h00, 8'h00, 8'h13, 3'd0, 3'b010);
        add("ld_inc",   LD | IN, 8'hFF, 8'h00, 8'hFF, 3'd0, 3'b010);
        add("inc_wrap", IN,      8'h00, 8'h00, 8'h00, 3'd0, 3'b010);
        add("load20",   LD,      8'h20, 8'h00, 8'h20, 3'd0, 3'b010);
        add("br_neg",   BR,      8'h00, 8'hF0, 8'h10, 3'd0, 3'b010);
        add("br_pos",   BR,      8'h00, 8'h05, 8'h15, 3'd0, 3'b010);
        add("loadFE",   LD,      8'hFE, 8'h00, 8'hFE, 3'd0, 3'b010);
        add("br_wrap",  BR,      8'h00, 8'h04, 8'h02, 3'd0, 3'b010);
        add("load13",   LD,      8'h13, 8'h00, 8'h13, 3'd0, 3'b010);
        add("call40",   CL,      8'h40, 8'h00, 8'h40, 3'd1, 3'b000);
        add("call80",   CL,      8'h80, 8'h00, 8'h80, 3'd2, 3'b000);
        add("ret41",    RT,      8'h00, 8'h00, 8'h41, 3'd1, 3'b000);
        add("ret14",    RT,      8'h00, 8'h00, 8'h14, 3'd0, 3'b010);
        add("call_ret", CL | RT, 8'h30, 8'h00, 8'h30, 3'd1, 3'b000);
        add("ret15",    RT,      8'h00, 8'h00, 8'h15, 3'd0, 3'b010);
        add("br_inc",   BR | IN, 8'h00, 8'h02, 8'h17, 3'd0, 3'b010);
        add("callA0",   CL,      8'hA0, 8'h00, 8'hA0, 3'd1, 3'b000);
        add("ld_call",  LD | CL, 8'h33, 8'h00, 8'h33, 3'd1, 3'b000);
        add("callA1",   CL,      8'hA1, 8'h00, 8'hA1, 3'd2, 3'b000);
        add("callA2",   CL,      8'hA2, 8'h00, 8'hA2, 3'd3, 3'b000);
        add("callA3",   CL,      8'hA3, 8'h00, 8'hA3, 3'd4, 3'b100);
        add("call_ovf", CL,      8'hB0, 8'h00, 8'hA3, 3'd4, 3'b101);
        add("retA3",    RT,      8'h00, 8'h00, 8'hA3, 3'd3, 3'b001);
        add("retA2",    RT,      8'h00, 8'h00, 8'hA2, 3'd2, 3'b001);
        add("ret34",    RT,      8'h00, 8'h00, 8'h34, 3'd1, 3'b001);
        add("ret18",    RT,      8'h00, 8'h00, 8'h18, 3'd0, 3'b011);
        add("ret_unf",  RT,      8'h00, 8'h00, 8'h18, 3'd0, 3'b011);
        add("clr_err",  CE,      8'h00, 8'h00, 8'h18, 3'd0, 3'b010);
        add("clr_ret",  CE | RT, 8'h00, 8'h00, 8'h18, 3'd0, 3'b011);
        add("clr2",     CE,      8'h00, 8'h00, 8'h18, 3'd0, 3'b010);
        add("hold",     NO,      8'h77, 8'h11, 8'h18, 3'd0, 3'b010);

        #3;
        check_all("reset0", 8'h00, 3'd0, 3'b010);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].cmd, vecs[i].data, vecs[i].off);
            check_all(vecs[i].name, vecs[i].e_count, vecs[i].e_sp, vecs[i].e_flags);
        end

        // Build sp=3, count=55, then pull reset between edges
        step(CL, 8'h01, 8'h00);
        step(CL, 8'h02, 8'h00);
        step(CL, 8'h03, 8'h00);
        step(LD, 8'h55, 8'h00);
        check_all("pre_rst", 8'h55, 3'd3, 3'b000);
        #2;
        rst = 1'b0;
        #1;
        check_all("async_rst", 8'h00, 3'd0, 3'b010);
        @(negedge clk);
        rst = 1'b1;
        step(RT, 8'h00, 8'h00);
        check_all("ret_after_rst", 8'h00, 3'd0, 3'b011);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
